frame_draw_scheduler: RTL



---
 rtl/frame_draw_scheduler.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/frame_draw_scheduler.sv
// Per-frame sequencer: steps the alien-group march, then starts each drawer in turn and
// forwards only the active drawer's pixel writes. Optional per-client watchdog: SCHED_WATCHDOG_EN.
module frame_draw_scheduler #(
  parameter int NUM_CLIENTS     = 3,
  parameter int MOVE_PERIOD     = 30,
  parameter int STEP_X          = 10,
  parameter int STEP_Y          = 10,
  parameter int LEFT_LIMIT      = 120,
  parameter int RIGHT_LIMIT     = 520,
  parameter int Y_LIMIT         = 400,
  parameter int START_X         = 320,
  parameter int START_Y         = 105,
  parameter int WATCHDOG_CYCLES = 400000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      frame_tick,
  input  logic [NUM_CLIENTS-1:0]    client_done,
  input  logic [10*NUM_CLIENTS-1:0] client_x,
  input  logic [9*NUM_CLIENTS-1:0]  client_y,
  input  logic [4*NUM_CLIENTS-1:0]  client_color,
  input  logic [NUM_CLIENTS-1:0]    client_wr,
  output logic [NUM_CLIENTS-1:0]    client_start,
  output logic [9:0]                fb_x,
  output logic [8:0]                fb_y,
  output logic [3:0]                fb_color,
  output logic                      fb_wr,
  output logic [9:0]                group_x,
  output logic [8:0]                group_y,
  output logic                      busy,
  output logic                      frame_overrun,
  output logic                      invaded,
  output logic                      timeout
);

  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int CNT_W = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLIENTS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MOVE_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MOVE, S_START, S_ARM, S_WAIT, S_NEXT
  } state_t;

  state_t                  r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [CNT_W-1:0]        r_frame_cnt;
  logic                    r_dir_left;
  logic [9:0]              r_group_x;
  logic [8:0]              r_group_y;
  logic [NUM_CLIENTS-1:0]  r_client_start;
  logic                    r_busy;
  logic                    r_overrun;
  logic                    r_invaded;

  // March arithmetic one bit wider than the coordinates so limit tests never wrap.
  logic [10:0] w_x_ext;
  logic [10:0] w_x_right;
  logic        w_hit_right;
  logic        w_hit_left;
  logic [9:0]  w_y_down;

  assign w_x_ext     = {1'b0, r_group_x};
  assign w_x_right   = w_x_ext + 11'(STEP_X);
  assign w_hit_right = (w_x_right > 11'(RIGHT_LIMIT));
  assign w_hit_left  = (w_x_ext < 11'(LEFT_LIMIT + STEP_X));
  assign w_y_down    = {1'b0, r_group_y} + 10'(STEP_Y);

`ifdef SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
  logic [WD_W-1:0] r_wd_cnt;
  logic            r_timeout;
  assign timeout = r_timeout;
`else
  logic w_unused_wd;
  assign w_unused_wd = (WATCHDOG_CYCLES == 0);
  assign timeout     = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_idx          <= '0;
      r_frame_cnt    <= '0;
      r_dir_left     <= 1'b0;
      r_group_x      <= 10'(START_X);
      r_group_y      <= 9'(START_Y);
      r_client_start <= '0;
      r_busy         <= 1'b0;
      r_overrun      <= 1'b0;
      r_invaded      <= 1'b0;
`ifdef SCHED_WATCHDOG_EN
      r_wd_cnt       <= '0;
      r_timeout      <= 1'b0;
`endif
    end else begin
      r_client_start <= '0;
      if (frame_tick && (r_state != S_IDLE)) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (frame_tick) begin
            r_state <= S_MOVE;
            r_busy  <= 1'b1;
          end
        end
        S_MOVE: begin
          if (r_frame_cnt == LAST_CNT) begin
            r_frame_cnt <= '0;
            if (!r_invaded) begin
              if ((r_dir_left && w_hit_left) || (!r_dir_left && w_hit_right)) begin
                r_group_y  <= w_y_down[8:0];
                r_dir_left <= !r_dir_left;
                if (w_y_down >= 10'(Y_LIMIT)) r_invaded <= 1'b1;
              end else if (r_dir_left) begin
                r_group_x <= r_group_x - 10'(STEP_X);
              end else begin
                r_group_x <= w_x_right[9:0];
              end
            end
          end else begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
          end
          r_idx             <= '0;
          r_client_start[0] <= 1'b1;
          r_state           <= S_START;
        end
        S_START: begin
`ifdef SCHED_WATCHDOG_EN
          r_wd_cnt <= '0;
`endif
          r_state <= S_ARM;
        end
        S_ARM: begin
          // Done from the previous frame may still be high here; it is not trusted.
`ifdef SCHED_WATCHDOG_EN
          r_wd_cnt <= r_wd_cnt + 1'b1;
`endif
          r_state <= S_WAIT;
        end
        S_WAIT: begin
`ifdef SCHED_WATCHDOG_EN
          r_wd_cnt <= r_wd_cnt + 1'b1;
          if (client_done[r_idx]) begin
            r_state <= S_NEXT;
          end else if (r_wd_cnt == WD_W'(WATCHDOG_CYCLES - 1)) begin
            r_timeout <= 1'b1;
            r_state   <= S_NEXT;
          end
`else
          if (client_done[r_idx]) r_state <= S_NEXT;
`endif
        end
        S_NEXT: begin
          if (r_idx == LAST_IDX) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_idx                          <= r_idx + 1'b1;
            r_client_start[r_idx + 1'b1]   <= 1'b1;
            r_state                        <= S_START;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Framebuffer port is a pure mux of the active client during its draw window.
  always_comb begin
    fb_x     = '0;
    fb_y     = '0;
    fb_color = '0;
    fb_wr    = 1'b0;
    if ((r_state == S_ARM) || (r_state == S_WAIT)) begin
      fb_x     = client_x[r_idx*10 +: 10];
      fb_y     = client_y[r_idx*9 +: 9];
      fb_color = client_color[r_idx*4 +: 4];
      fb_wr    = client_wr[r_idx];
    end
  end

  assign client_start  = r_client_start;
  assign group_x       = r_group_x;
  assign group_y       = r_group_y;
  assign busy          = r_busy;
  assign frame_overrun = r_overrun;
  assign invaded       = r_invaded;

endmodule
